counter_backward: RTL and testbench

//  Down-counter, the decrementing counterpart of counter_forward.

---
 rtl/counter_backward.sv | 95 +++++++++
 tb/tb_counter_backward.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/counter_backward.sv
// Down-counter with load, wrap/saturate/reload handling at zero, an early
// borrow flag, a one-cycle zero pulse, a sticky underflow flag and a small
// IDLE/RUN/DONE state machine whose RUN state is exported as busy_o.
module counter_backward #(
    parameter int WORD_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  arst_ni,
    input  logic                  en_i,
    input  logic                  action_i,
    input  logic [1:0]            mode_i,
    input  logic [WORD_WIDTH-1:0] data_i,
    output logic [WORD_WIDTH-1:0] data_o,
    output logic                  will_underflow_o,
    output logic                  zero_o,
    output logic                  underflow_o,
    output logic                  busy_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    localparam logic [1:0] MODE_SATURATE = 2'b01;
    localparam logic [1:0] MODE_RELOAD   = 2'b10;

    localparam logic [WORD_WIDTH-1:0] ALL_ZERO = '0;
    localparam logic [WORD_WIDTH-1:0] ALL_ONES = '1;
    localparam logic [WORD_WIDTH-1:0] ONE      = {{(WORD_WIDTH-1){1'b0}}, 1'b1};

    state_t state;

    // The next decrement borrows whenever the registered count sits at zero.
    assign will_underflow_o = (data_o == ALL_ZERO);

    // Count register, flags and state machine all advance together so busy_o stays aligned with state.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            data_o      <= ALL_ZERO;
            zero_o      <= 1'b0;
            underflow_o <= 1'b0;
            busy_o      <= 1'b0;
            state       <= ST_IDLE;
        end else if (!en_i) begin
            zero_o <= 1'b0;
        end else if (!action_i) begin
            data_o      <= data_i;
            zero_o      <= 1'b0;
            underflow_o <= 1'b0;
            if (data_i != ALL_ZERO) begin
                state  <= ST_RUN;
                busy_o <= 1'b1;
            end else begin
                state  <= ST_IDLE;
                busy_o <= 1'b0;
            end
        end else if (data_o != ALL_ZERO) begin
            data_o <= data_o - ONE;
            if (data_o == ONE) begin
                zero_o <= 1'b1;
                state  <= ST_DONE;
                busy_o <= 1'b0;
            end else begin
                zero_o <= 1'b0;
            end
        end else begin
            underflow_o <= 1'b1;
            if (mode_i == MODE_SATURATE) begin
                data_o <= ALL_ZERO;
                zero_o <= 1'b1;
                state  <= ST_DONE;
                busy_o <= 1'b0;
            end else if (mode_i == MODE_RELOAD) begin
                data_o <= data_i;
                if (data_i != ALL_ZERO) begin
                    zero_o <= 1'b0;
                    state  <= ST_RUN;
                    busy_o <= 1'b1;
                end else begin
                    zero_o <= 1'b1;
                    state  <= ST_DONE;
                    busy_o <= 1'b0;
                end
            end else begin
                data_o <= ALL_ONES;
                zero_o <= 1'b0;
                state  <= ST_RUN;
                busy_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_counter_backward.sv
// Directed testbench for counter_backward at WORD_WIDTH=8 with hand-computed
// expected values for every observed output.
module tb_counter_backward;

    logic       clk_i;
    logic       arst_ni;
    logic       en_i;
    logic       action_i;
    logic [1:0] mode_i;
    logic [7:0] data_i;
    logic [7:0] data_o;
    logic       will_underflow_o;
    logic       zero_o;
    logic       underflow_o;
    logic       busy_o;

    int checks_done;
    int checks_failed;

    counter_backward #(.WORD_WIDTH(8)) dut (
        .clk_i            (clk_i),
        .arst_ni          (arst_ni),
        .en_i             (en_i),
        .action_i         (action_i),
        .mode_i           (mode_i),
        .data_i           (data_i),
        .data_o           (data_o),
        .will_underflow_o (will_underflow_o),
        .zero_o           (zero_o),
        .underflow_o      (underflow_o),
        .busy_o           (busy_o)
    );

    // Free-running 10 ns clock.
    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Compare one observed value against its expected value and tally the result.
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks_done++;
        if (actual !== expected) begin
            checks_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    // Check the full registered output set in one call.
    task automatic checkAll(input string tag, input logic [7:0] d, input logic z,
                            input logic uf, input logic b);
        checkOutput({tag, ".data"}, {24'd0, data_o}, {24'd0, d});
        checkOutput({tag, ".zero"}, {31'd0, zero_o}, {31'd0, z});
        checkOutput({tag, ".uflow"}, {31'd0, underflow_o}, {31'd0, uf});
        checkOutput({tag, ".busy"}, {31'd0, busy_o}, {31'd0, b});
        checkOutput({tag, ".will"}, {31'd0, will_underflow_o}, {31'd0, (d == 8'd0)});
    endtask

    // Drive one cycle of inputs, let the next rising edge take them, then settle.
    task automatic applyStimulus(input logic en, input logic act, input logic [1:0] mode,
                                 input logic [7:0] data);
        en_i     = en;
        action_i = act;
        mode_i   = mode;
        data_i   = data;
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        checks_done   = 0;
        checks_failed = 0;
        arst_ni  = 1'b0;
        en_i     = 1'b0;
        action_i = 1'b0;
        mode_i   = 2'b00;
        data_i   = 8'd0;

        // Reset values, including the combinational borrow flag.
        repeat (2) @(posedge clk_i);
        #1;
        checkAll("reset", 8'd0, 1'b0, 1'b0, 1'b0);
        arst_ni = 1'b1;
        #1;
        checkAll("reset_release", 8'd0, 1'b0, 1'b0, 1'b0);

        // Load 3 and count down to zero.
        applyStimulus(1'b1, 1'b0, 2'b00, 8'd3);
        checkAll("ld3", 8'd3, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b1, 2'b00, 8'd0);
        checkAll("dec2", 8'd2, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b1, 2'b00, 8'd0);
        checkAll("dec1", 8'd1, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b1, 2'b00, 8'd0);
        checkAll("dec0", 8'd0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 2'b00, 8'd0);
        checkAll("hold0", 8'd0, 1'b0, 1'b0, 1'b0);

        // Wrap mode borrow, sticky underflow, then cleared by load.
        applyStimulus(1'b1, 1'b1, 2'b00, 8'd0);
        checkAll("wrap", 8'd255, 1'b0, 1'b1, 1'b1);
        applyStimulus(1'b1, 1'b1, 2'b11, 8'd0);
        checkAll("wrap_dec", 8'd254, 1'b0, 1'b1, 1'b1);
        applyStimulus(1'b1, 1'b0, 2'b00, 8'd5);
        checkAll("ld5", 8'd5, 1'b0, 1'b0, 1'b1);

        // Mode 11 behaves as wrap.
        applyStimulus(1'b1, 1'b0, 2'b11, 8'd0);
        checkAll("ld0", 8'd0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 2'b11, 8'd0);
        checkAll("wrap11", 8'd255, 1'b0, 1'b1, 1'b1);

        // Saturate mode: stays at zero, pulses zero every borrow.
        applyStimulus(1'b1, 1'b0, 2'b01, 8'd1);
        applyStimulus(1'b1, 1'b1, 2'b01, 8'd0);
        checkAll("sat_reach", 8'd0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 2'b01, 8'd0);
        checkAll("sat1", 8'd0, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 2'b01, 8'd0);
        checkAll("sat2", 8'd0, 1'b1, 1'b1, 1'b0);

        // Reload mode: 1 -> 0 -> 4 -> 3 ... -> 0, then reload of 0.
        applyStimulus(1'b1, 1'b0, 2'b10, 8'd1);
        applyStimulus(1'b1, 1'b1, 2'b10, 8'd4);
        checkAll("rl_zero", 8'd0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 2'b10, 8'd4);
        checkAll("rl_reload", 8'd4, 1'b0, 1'b1, 1'b1);
        applyStimulus(1'b1, 1'b1, 2'b10, 8'd99);
        checkAll("rl_3", 8'd3, 1'b0, 1'b1, 1'b1);
        applyStimulus(1'b1, 1'b1, 2'b10, 8'd99);
        applyStimulus(1'b1, 1'b1, 2'b10, 8'd99);
        applyStimulus(1'b1, 1'b1, 2'b10, 8'd99);
        checkAll("rl_down0", 8'd0, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 2'b10, 8'd0);
        checkAll("rl_reload0", 8'd0, 1'b1, 1'b1, 1'b0);

        // Enable low holds the count and suppresses the zero pulse, even for loads.
        applyStimulus(1'b1, 1'b0, 2'b00, 8'd9);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b1, 2'b00, 8'd0);
            checkAll("en_hold", 8'd9, 1'b0, 1'b0, 1'b1);
        end
        applyStimulus(1'b0, 1'b0, 2'b00, 8'd77);
        checkAll("en_noload", 8'd9, 1'b0, 1'b0, 1'b1);

        // Asynchronous reset mid-count with underflow set, no clock edge needed.
        applyStimulus(1'b1, 1'b0, 2'b10, 8'd0);
        applyStimulus(1'b1, 1'b1, 2'b10, 8'd37);
        checkAll("pre_rst", 8'd37, 1'b0, 1'b1, 1'b1);
        en_i = 1'b0;
        #2;
        arst_ni = 1'b0;
        #1;
        checkAll("async_rst", 8'd0, 1'b0, 1'b0, 1'b0);
        @(posedge clk_i);
        #3;
        arst_ni = 1'b1;
        applyStimulus(1'b1, 1'b0, 2'b00, 8'd6);
        checkAll("post_rst_ld", 8'd6, 1'b0, 1'b0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", checks_done, checks_failed);
        $finish;
    end

endmodule
